// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: state encoding,
// parameter legality check and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int MIN_DATA_W    = 5;
    localparam int MAX_DATA_W    = 9;
    localparam int MIN_STOP_BITS = 1;
    localparam int MAX_STOP_BITS = 2;

    function automatic bit params_legal(input int data_w, input int stop_bits);
        return (data_w >= MIN_DATA_W) && (data_w <= MAX_DATA_W) &&
               (stop_bits >= MIN_STOP_BITS) && (stop_bits <= MAX_STOP_BITS);
    endfunction

    // Callers zero-extend narrower words; the extra zeros do not change parity.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// Single-entry holding register in front of the transmit shifter, with
// ready/overrun handshake.
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bypass,
    input  logic              load,
    output logic              ready,
    output logic              overrun,
    output logic              hold_valid,
    output logic [DATA_W-1:0] hold_data
);

    logic              hold_valid_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic              accept;

    assign ready      = ~hold_valid_reg;
    // An idle transmitter takes the word straight into its shifter instead.
    assign accept     = wr_enb & ready & ~bypass;
    assign overrun    = wr_enb & ~ready & ~rst;
    assign hold_valid = hold_valid_reg;
    assign hold_data  = hold_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (accept) begin
            hold_data_reg  <= data_in;
            hold_valid_reg <= 1'b1;
        end else if (load) begin
            hold_valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Framed UART transmitter: DATA_W data bits LSB first, optional parity,
// 1 or 2 stop bits, paced by an external baud strobe.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              wr_enb,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);

    generate
        if (!params_legal(DATA_W, STOP_BITS)) begin : g_param_check
            $error("uart_tx_frame: DATA_W must be 5..9 and STOP_BITS 1..2");
        end
    endgenerate

    tx_state_t         state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              stop_cnt_reg;
    logic              tx_reg;

    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic              hold_load;
    logic              last_stop;
    logic              frame_end;

    assign last_stop = (STOP_BITS == 1) || stop_cnt_reg;
    assign frame_end = (state_reg == ST_STOP) && enb && last_stop;
    assign hold_load = hold_valid && ((state_reg == ST_IDLE) || frame_end);

    assign tx   = tx_reg;
    assign busy = (state_reg != ST_IDLE);
    assign done = frame_end & ~rst;

    uart_tx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .wr_enb     (wr_enb),
        .data_in    (data_in),
        .bypass     (state_reg == ST_IDLE),
        .load       (hold_load),
        .ready      (ready),
        .overrun    (overrun),
        .hold_valid (hold_valid),
        .hold_data  (hold_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tx_reg       <= 1'b1;
            shift_reg    <= '0;
            idx_reg      <= '0;
            stop_cnt_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (hold_valid) begin
                        shift_reg <= hold_data;
                        idx_reg   <= '0;
                        state_reg <= ST_START;
                    end else if (wr_enb) begin
                        shift_reg <= data_in;
                        idx_reg   <= '0;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (enb) begin
                        tx_reg    <= 1'b0;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (enb) begin
                        tx_reg <= shift_reg[idx_reg];
                        if (idx_reg == LAST_IDX) begin
                            stop_cnt_reg <= 1'b0;
                            state_reg    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (enb) begin
                        tx_reg    <= parity_bit(MAX_DATA_W'(shift_reg), ODD_BIT);
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (enb) begin
                        tx_reg <= 1'b1;
                        if (!last_stop) begin
                            stop_cnt_reg <= 1'b1;
                        end else begin
                            stop_cnt_reg <= 1'b0;
                            // Chain straight into the next start bit when a word is waiting.
                            if (hold_valid) begin
                                shift_reg <= hold_data;
                                idx_reg   <= '0;
                                state_reg <= ST_START;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
